// File: rtl/fir_sample_driver.sv
// fir_sample_driver
//   Initiator for the fir_filter_beta sample handshake. Takes Q1.9 samples
//   on a valid/ready input, converts each one to the 10-bit float format
//   {sign, exp[3:0] bias 7, mant[4:0] hidden 1; exp 0 = zero}, pulses
//   fir_en, waits for a fresh fir_out_avl rise, and converts fir_out back
//   to Q1.9 on a valid/ready output. One sample in flight at a time.
//
// Optional build macro: FIR_DRV_TIMEOUT_EN adds a wait-state timeout and
//   the err output. Without it the wait states wait indefinitely.
//
// Ports:
//   clk_fast, rst (async, active low)
//   s_valid/s_ready/s_data  : Q1.9 sample input
//   fir_in/fir_en           : float sample + one-cycle start pulse
//   fir_out/fir_out_avl     : float result + result-available level
//   m_valid/m_ready/m_data  : Q1.9 result output
//   busy                    : high whenever not IDLE
//   err                     : one-cycle timeout pulse (macro builds only)
module fir_sample_driver #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [9:0] s_data,
  output logic       s_ready,
  output logic [9:0] fir_in,
  output logic       fir_en,
  input  logic [9:0] fir_out,
  input  logic       fir_out_avl,
  output logic       m_valid,
  output logic [9:0] m_data,
  input  logic       m_ready,
  output logic       busy
`ifdef FIR_DRV_TIMEOUT_EN
  ,
  output logic       err
`endif
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_chk
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {IDLE, CONV, ISSUE, WAIT_LO, WAIT_HI, OUTPUT} state_t;

  state_t     r_state;
  logic [9:0] r_sample;
  logic [9:0] r_fir_in;
  logic       r_fir_en;
  logic       r_m_valid;
  logic [9:0] r_m_data;

  // Q1.9 -> float. Magnitude is taken at 10 bits so -512 stays 512.
  // Normalising the MSB to bit 9 gives the mantissa (zero-padded) in [8:4].
  function automatic logic [9:0] fix2flt(input logic [9:0] x);
    logic [9:0] mag, sh;
    logic [3:0] p;
    logic [9:0] res;
    mag = x[9] ? (~x + 10'd1) : x;
    p   = 4'd0;
    for (int i = 0; i < 10; i++)
      if (mag[i]) p = 4'(i);
    sh = mag << (4'd9 - p);
    if (mag < 10'd4) res = 10'h000;
    else             res = {x[9], 4'(p - 4'd2), sh[8:4]};
    return res;
  endfunction

  // float -> Q1.9, truncating toward zero, saturating at +511 / -512.
  function automatic logic [9:0] flt2fix(input logic [9:0] f);
    logic [20:0] v;
    logic [3:0]  e;
    logic [9:0]  res;
    e = f[8:5];
    v = {15'd0, 1'b1, f[4:0]};
    if (e >= 4'd3) v = v << (e - 4'd3);
    else           v = v >> (4'd3 - e);
    if (e == 4'd0)          res = 10'h000;
    else if (v >= 21'd512)  res = f[9] ? 10'h200 : 10'h1FF;
    else                    res = f[9] ? (~v[9:0] + 10'd1) : v[9:0];
    return res;
  endfunction

`ifdef FIR_DRV_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_to;
  assign w_to = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err  = r_err;
`endif

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_sample  <= '0;
      r_fir_in  <= '0;
      r_fir_en  <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
`ifdef FIR_DRV_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      // fir_en is high exactly for the ISSUE cycle.
      r_fir_en <= (r_state == CONV);
`ifdef FIR_DRV_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        IDLE: if (s_valid) begin
          r_sample <= s_data;
          r_state  <= CONV;
        end
        CONV: begin
          r_fir_in <= fix2flt(r_sample);
          r_state  <= ISSUE;
        end
        ISSUE: begin
`ifdef FIR_DRV_TIMEOUT_EN
          r_cnt <= '0;
`endif
          r_state <= WAIT_LO;
        end
        // Only a low level proves the filter re-armed; a high level here
        // may be left over from the previous sample.
        WAIT_LO: begin
          if (!fir_out_avl) r_state <= WAIT_HI;
`ifdef FIR_DRV_TIMEOUT_EN
          else if (w_to) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
          r_cnt <= r_cnt + 1'b1;
`endif
        end
        WAIT_HI: begin
          if (fir_out_avl) begin
            r_m_data  <= flt2fix(fir_out);
            r_m_valid <= 1'b1;
            r_state   <= OUTPUT;
          end
`ifdef FIR_DRV_TIMEOUT_EN
          else if (w_to) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
          r_cnt <= r_cnt + 1'b1;
`endif
        end
        OUTPUT: if (m_ready) begin
          r_m_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready = (r_state == IDLE);
  assign busy    = (r_state != IDLE);
  assign fir_in  = r_fir_in;
  assign fir_en  = r_fir_en;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;

endmodule

// File: tb/tb_fir_sample_driver.sv
module tb_fir_sample_driver;
  logic       clk_fast = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic [9:0] s_data = '0;
  logic       s_ready;
  logic [9:0] fir_in;
  logic       fir_en;
  logic [9:0] fir_out = '0;
  logic       fir_out_avl = 1'b0;
  logic       m_valid;
  logic [9:0] m_data;
  logic       m_ready = 1'b1;
  logic       busy;
`ifdef FIR_DRV_TIMEOUT_EN
  logic       err;
`endif

  localparam int TO = 10;

  fir_sample_driver #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_fast(clk_fast), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_in(fir_in), .fir_en(fir_en),
    .fir_out(fir_out), .fir_out_avl(fir_out_avl),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy)
`ifdef FIR_DRV_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk_fast = ~clk_fast;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb[$];

  typedef struct {
    logic [9:0] sd;
    logic [9:0] fin;
    logic [9:0] fo;
    logic [9:0] md;
    bit         stale;
    bit         bp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {9'd0, act}, {9'd0, exp});
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [9:0] e;
    if (v.stale) begin fir_out_avl = 1'b1; fir_out = 10'h155; end
    else         fir_out_avl = 1'b0;
    chk1("idle_s_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_data = v.sd;
    @(negedge clk_fast);
    s_valid = 1'b0;
    chk1("conv_fir_en", fir_en, 1'b0);
    chk1("conv_busy", busy, 1'b1);
    chk1("conv_s_ready", s_ready, 1'b0);
    @(negedge clk_fast);
    chk1("issue_fir_en", fir_en, 1'b1);
    chk("fir_in", fir_in, v.fin);
    @(negedge clk_fast);
    chk1("wait_fir_en", fir_en, 1'b0);
    if (v.stale) begin
      repeat (2) @(negedge clk_fast);
      chk1("stale_no_mvalid", m_valid, 1'b0);
      fir_out_avl = 1'b0;
      repeat (3) @(negedge clk_fast);
    end else begin
      @(negedge clk_fast);
    end
    chk1("pre_result_mvalid", m_valid, 1'b0);
    fir_out = v.fo; fir_out_avl = 1'b1; m_ready = !v.bp;
    sb.push_back(v.md);
    n = 0;
    do begin @(negedge clk_fast); n++; end while (!m_valid && n < 20);
    chki("result_latency", n, 1);
    e = sb.pop_front();
    chk("m_data", m_data, e);
    if (v.bp) begin
      repeat (5) begin
        s_valid = 1'b1; s_data = 10'h155;
        @(negedge clk_fast);
        chk1("bp_m_valid", m_valid, 1'b1);
        chk("bp_m_data", m_data, e);
        chk1("bp_s_ready", s_ready, 1'b0);
        chk1("bp_fir_en", fir_en, 1'b0);
      end
      s_valid = 1'b0; m_ready = 1'b1;
    end
    @(negedge clk_fast);
    chk1("done_m_valid", m_valid, 1'b0);
    chk1("done_s_ready", s_ready, 1'b1);
    chk1("done_busy", busy, 1'b0);
  endtask

  initial begin
    //           sd      fin     fo      md      stale bp
    vecs[0] = '{10'h100, 10'h0C0, 10'h0C0, 10'h100, 0, 0};
    vecs[1] = '{10'h200, 10'h2E0, 10'h0F0, 10'h1FF, 0, 0};
    vecs[2] = '{10'h003, 10'h000, 10'h2A8, 10'h360, 0, 0};
    vecs[3] = '{10'h1FF, 10'h0DF, 10'h000, 10'h000, 1, 0};
    vecs[4] = '{10'h3FC, 10'h200, 10'h2F0, 10'h200, 0, 0};
    vecs[5] = '{10'h00A, 10'h028, 10'h028, 10'h00A, 0, 1};
    vecs[6] = '{10'h2C0, 10'h2C8, 10'h2C8, 10'h2C0, 0, 0};
    vecs[7] = '{10'h001, 10'h000, 10'h1E0, 10'h1FF, 0, 0};
    vecs[8] = '{10'h040, 10'h080, 10'h05F, 10'h01F, 0, 0};

    // reset values
    #12;
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_fir_en", fir_en, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk("rst_fir_in", fir_in, 10'h000);
    chk("rst_m_data", m_data, 10'h000);
    @(negedge clk_fast);
    rst = 1'b1;
    @(negedge clk_fast);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // reset asserted while waiting for the result abandons the sample
    fir_out_avl = 1'b0;
    s_valid = 1'b1; s_data = 10'h100;
    @(negedge clk_fast);
    s_valid = 1'b0;
    repeat (3) @(negedge clk_fast);
    chk1("midrst_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_fir_in", fir_in, 10'h000);
    chk("midrst_m_data", m_data, 10'h000);
    chk1("midrst_fir_en", fir_en, 1'b0);
    chk1("midrst_m_valid", m_valid, 1'b0);
    chk1("midrst_s_ready", s_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    fir_out = 10'h0C0; fir_out_avl = 1'b1;
    @(negedge clk_fast);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk_fast);
      chk1("postrst_no_mvalid", m_valid, 1'b0);
    end
    chk1("postrst_s_ready", s_ready, 1'b1);
    fir_out_avl = 1'b0;

`ifdef FIR_DRV_TIMEOUT_EN
    begin
      int n;
      s_valid = 1'b1; s_data = 10'h100;
      @(negedge clk_fast);
      s_valid = 1'b0;
      @(negedge clk_fast);
      @(negedge clk_fast);
      chk1("to_issue", fir_en, 1'b1);
      n = 0;
      do begin @(negedge clk_fast); n++; end while (!err && n < 40);
      chki("to_err_delay", n, TO + 1);
      chk1("to_m_valid", m_valid, 1'b0);
      chk1("to_s_ready", s_ready, 1'b1);
      @(negedge clk_fast);
      chk1("to_err_pulse", err, 1'b0);
      chk1("to_m_valid2", m_valid, 1'b0);
    end
`endif

    chki("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_sample_driver.md
Name: fir_sample_driver

Overview:
- Initiator side of the fir_filter_beta sample handshake; sits between the fixed-point sample stream and the filter.
- Accepts Q1.9 two's-complement samples on a valid/ready input and converts each one to the team's 10-bit float format.
- Drives fir_in and a one-cycle en pulse, then waits for fir_out_avl and captures fir_out.
- Converts the captured result back to Q1.9 and presents it on a valid/ready output.
- One sample in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255, cycles allowed between the en pulse and fir_out_avl rising (used only with the optional feature).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_fast  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_data  in  10  input sample, Q1.9 two's complement.
- s_ready  out  1  driver can accept a sample.
- fir_in  out  10  float sample to the filter.
- fir_en  out  1  one-cycle start pulse to the filter.
- fir_out  in  10  float result from the filter.
- fir_out_avl  in  1  filter result-available level.
- m_valid  out  1  output sample valid.
- m_data  out  10  output sample, Q1.9 two's complement.
- m_ready  in  1  downstream accepts the output sample.
- busy  out  1  high in every state except IDLE.
- err  out  1  timeout flag; exists only with FIR_DRV_TIMEOUT_EN.

Behaviour:
- Float format:
  - bit9 = sign, bits8:5 = exponent (bias 7), bits4:0 = mantissa with hidden 1.
  - exponent 0 means zero.
- Reset (rst low, asynchronous):
  - state = IDLE.
  - fir_in, m_data = 0.
  - fir_en, m_valid, err = 0.
  - s_ready = 1, busy = 0.
  - Reset asserted mid-operation abandons the sample; no m_valid is produced for it.
- FSM states: IDLE, CONV, ISSUE, WAIT_LO, WAIT_HI, OUTPUT.
  - IDLE: s_ready = 1. On s_valid & s_ready, register s_data and go to CONV.
  - CONV (1 cycle): register the converted float into fir_in, then go to ISSUE. fir_in holds stable until the next CONV.
  - ISSUE (1 cycle): fir_en = 1, then go to WAIT_LO. fir_en is low in every other state.
  - WAIT_LO: wait for fir_out_avl = 0 (filter has re-armed), then go to WAIT_HI. This rejects a stale high level left from the previous sample.
  - WAIT_HI: on fir_out_avl = 1, back-convert fir_out into m_data, set m_valid = 1, go to OUTPUT.
  - OUTPUT: hold m_valid and m_data stable. On m_valid & m_ready, clear m_valid and go to IDLE.
- Latency: handshake at edge T gives fir_en high during cycle T+2. Result handshake to m_valid high takes 1 cycle.
- Fixed to float:
  - mag = |s_data|, 10 bits, so -512 gives 512.
  - p = index of the MSB set in mag.
  - If mag < 4: result is 0x000 (sign dropped).
  - Otherwise: exponent = p-2; mantissa = the 5 bits below the MSB, truncated, zero-padded on the right when p < 5; sign = s_data[9].
- Float to fixed (round toward zero):
  - e = 0: result 0.
  - Otherwise mag = (32+mant) * 2^(e-3).
  - If mag ≥ 512: saturate to +511 (0x1FF) for positive, -512 (0x200) for negative.
  - Otherwise the result is ±mag in two's complement.
- Simultaneous events:
  - s_valid is ignored outside IDLE.
  - fir_out_avl changes outside WAIT_LO/WAIT_HI are ignored.
  - m_ready while m_valid = 0 has no effect.

Optional Feature:
- Macro: FIR_DRV_TIMEOUT_EN.
- With the macro:
  - A CNT_W counter clears in ISSUE and increments in WAIT_LO and WAIT_HI.
  - On reaching TIMEOUT_CYCLES: err pulses high for 1 cycle, the state returns to IDLE, and no m_valid is produced.
  - The err port exists.
- Without the macro:
  - No counter; WAIT states wait indefinitely.
  - The err port is absent.

Test Plan:
- Reset: rst low mid-WAIT_HI, then high -> all outputs at reset values; s_ready = 1; no m_valid.
- Round trip: s_data 0x100 (+0.5) -> fir_in 0x0C0, single fir_en pulse at T+2. Model returns fir_out 0x0C0 -> m_data 0x100, m_valid high.
- Extremes: s_data 0x200 (-1.0) -> fir_in 0x2E0. s_data 0x003 -> fir_in 0x000. fir_out 0x0F0 -> m_data 0x1FF (saturate). fir_out 0x2A8 -> m_data 0x360 (-160).
- Stale avl: fir_out_avl held high through ISSUE, low 3 cycles, then high -> capture only on the second rise.
- Backpressure: m_ready low 5 cycles -> m_valid and m_data stable, s_ready = 0, no new fir_en. After m_ready high, IDLE next cycle.
- Timeout (macro on, TIMEOUT_CYCLES = 10): fir_out_avl stuck low -> err pulse 10 cycles after ISSUE, IDLE, m_valid stays 0.
